muldiv_divider: RTL and testbench
=================================

Name: muldiv_divider

Overview:
- Iterative multi-cycle integer divider implementing the RISC-V M-extension DIV, DIVU, REM and REMU operations.
- Sits beside the single-cycle ALU in the execute stage and takes the same 32-bit operands.
- Uses a valid/ready request and result handshake so the pipeline stalls while the divider is busy.
- Reports the RISC-V corner cases (divide-by-zero, signed overflow) as flags, in the same style as the ALU flags.

Parameters:
- XLEN, 32, operand and result width. 32 is the only supported value; the counter is sized as clog2(XLEN)+1 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of any in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept a request.
- div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  XLEN  operand1.
- divisor  input  XLEN  operand2.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  quotient or remainder, selected by div_op.
- div_by_zero_flag  output  1  divisor was 0.
- overflow_flag  output  1  signed DIV/REM of 0x80000000 by 0xFFFFFFFF.

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=IDLE, in_ready=1, out_valid=0, result=0, both flags=0, all internal registers 0.
  - Takes effect mid-operation with no result produced.
- States: IDLE, CALC, FIX, DONE.
- in_ready is 1 only in IDLE with flush=0.
- Accept condition: in_valid & in_ready at a rising edge. On accept, latch div_op.
  - Signed ops (DIV, REM): latch the absolute values of the operands, the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]).
  - Unsigned ops: latch the raw operands.
- Special cases, checked at accept; next state is DONE (out_valid 1 cycle after accept):
  - divisor==0: quotient=all ones, remainder=dividend (original, unmodified), div_by_zero_flag=1. Applies to signed and unsigned ops.
  - Signed op with dividend==0x80000000 and divisor==0xFFFFFFFF: quotient=0x80000000, remainder=0, overflow_flag=1.
- Normal path: next state CALC, counter=XLEN.
- CALC performs one restoring-division step per cycle, for exactly XLEN cycles:
  - Shift {rem, quo} left by 1.
  - Trial subtract of the divisor from rem using a 33-bit subtract (carry-out = no borrow).
  - If no borrow, rem takes the difference and quo LSB=1.
  - Decrement the counter; move to FIX when it reaches 0.
- FIX (1 cycle):
  - Negate the quotient if the quotient sign is set and the op is signed.
  - Negate the remainder if the remainder sign is set and the op is signed.
  - Register result per div_op; next state DONE.
- Normal latency: out_valid rises XLEN+2 cycles after the accept edge (34 for XLEN=32).
- DONE:
  - out_valid=1; result and flags stay stable until the handshake.
  - On out_valid & out_ready, go to IDLE. out_valid falls on that edge and the flags clear.
  - No new request is accepted in the handshake cycle (in_ready=0 in DONE).
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- flush=1 at any edge:
  - Next state IDLE, out_valid=0, flags=0, no result delivered.
  - A coincident in_valid is not accepted.
  - flush in DONE discards the pending result even if out_ready=1.
- Operands change after accept: no effect, because all operands are latched.
- A zero dividend takes the normal path and yields quotient 0, remainder 0.
- The flags are meaningful only while out_valid=1 and are 0 otherwise.

Test Plan:
- DIVU 100/7 -> result 14 after 34 cycles, flags 0. REMU 100/7 -> 2. out_ready held high; in_ready returns to 1 the cycle after the handshake.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIV 7/0xFFFFFFFE (-2) -> 0xFFFFFFFD. REM 7/-2 -> 1.
- DIVU 0x1234/0 -> 0xFFFFFFFF with div_by_zero_flag=1 one cycle after accept. REMU 0x1234/0 -> 0x1234. REM 0xFFFFFFF9/0 -> 0xFFFFFFF9.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, overflow_flag=1, 1-cycle latency. REM with the same operands -> 0, overflow_flag=1. DIVU with the same operands -> 0 via the normal 34-cycle path, flags 0.
- Backpressure: DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF. Hold out_ready=0 for 5 cycles: result, flags and out_valid remain stable and in_ready stays 0; then raise out_ready and check a single transfer.
- Kill and reset:
  - Assert flush at CALC cycle 10 -> IDLE next cycle, no out_valid pulse. A new DIVU 9/3 then returns 3.
  - Repeat, dropping rst_n asynchronously mid-CALC -> all outputs immediately at reset values.

Source files
------------

// File: rtl/muldiv_divider.sv
// ============================================================================
//  Module      : muldiv_divider
//  Description : Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
//                Valid/ready request and result handshakes; corner-case flags.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero_flag,
    output logic            overflow_flag
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] C_ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   C_CNT_INIT = CW'(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [1:0]        op_q,        op_d;
    logic [XLEN-1:0]   rem_q,       rem_d;
    logic [XLEN-1:0]   quo_q,       quo_d;
    logic [XLEN-1:0]   dsr_q,       dsr_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic              qsign_q,     qsign_d;
    logic              rsign_q,     rsign_d;
    logic [XLEN-1:0]   result_q,    result_d;
    logic              out_valid_q, out_valid_d;
    logic              dbz_q,       dbz_d;
    logic              ovf_q,       ovf_d;

    logic              w_req_signed;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    assign w_req_signed = ~div_op[0];
    assign w_abs_a      = dividend[XLEN-1] ? (~dividend + C_ONE) : dividend;
    assign w_abs_b      = divisor[XLEN-1]  ? (~divisor  + C_ONE) : divisor;

    // Remainder stays below the divisor, so a 33-bit trial subtract suffices:
    // bit XLEN of the difference is set exactly when the subtract borrows.
    assign w_shift   = {rem_q, quo_q[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, dsr_q};

    assign w_quo_fix = qsign_q ? (~quo_q + C_ONE) : quo_q;
    assign w_rem_fix = rsign_q ? (~rem_q + C_ONE) : rem_q;

    assign in_ready         = (state_q == IDLE) && !flush;
    assign out_valid        = out_valid_q;
    assign result           = result_q;
    assign div_by_zero_flag = dbz_q;
    assign overflow_flag    = ovf_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d = div_op;
                    if (divisor == '0) begin
                        result_d    = div_op[1] ? dividend : '1;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (w_req_signed && dividend == C_MIN_NEG && divisor == '1) begin
                        result_d    = div_op[1] ? '0 : C_MIN_NEG;
                        ovf_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = w_req_signed ? w_abs_a : dividend;
                        dsr_d   = w_req_signed ? w_abs_b : divisor;
                        qsign_d = w_req_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        rsign_d = w_req_signed & dividend[XLEN-1];
                        cnt_d   = C_CNT_INIT;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!w_diff[XLEN]) begin
                    rem_d = w_diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = w_shift[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d    = op_q[1] ? w_rem_fix : w_quo_fix;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_divider.sv
// ============================================================================
//  Module      : tb_muldiv_divider
//  Description : Directed self-checking bench for muldiv_divider.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Accept edge to DONE edge on the normal path (out_valid seen in cycle 34).
    localparam int LAT_NORMAL  = 33;
    localparam int LAT_SPECIAL = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        div_by_zero_flag;
    logic        overflow_flag;

    int total_checks = 0;
    int fail_checks  = 0;

    muldiv_divider #(.XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .div_op           (div_op),
        .dividend         (dividend),
        .divisor          (divisor),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .div_by_zero_flag (div_by_zero_flag),
        .overflow_flag    (overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) else begin
            fail_checks++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the operand inputs.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        div_op   = op;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        div_op   = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_dbz, input logic exp_ovf);
        int lat;
        issue(op, a, b);
        wait_valid(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " dbz"}, {31'd0, div_by_zero_flag}, {31'd0, exp_dbz});
        check({tag, " ovf"}, {31'd0, overflow_flag}, {31'd0, exp_ovf});
        @(posedge clk);
        #1;
        check({tag, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
        check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
        check({tag, " flags after handshake"}, {30'd0, div_by_zero_flag, overflow_flag}, 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] held;

        // Reset state
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {30'd0, div_by_zero_flag, overflow_flag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Unsigned normal path
        run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, LAT_NORMAL, 32'd14, 1'b0, 1'b0);
        run_op("REMU 100/7", OP_REMU, 32'd100, 32'd7, LAT_NORMAL, 32'd2, 1'b0, 1'b0);

        // Signed normal path
        run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, LAT_NORMAL, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, LAT_NORMAL, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, LAT_NORMAL, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("REM 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, LAT_NORMAL, 32'd1, 1'b0, 1'b0);
        run_op("DIVU big/big", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORMAL, 32'd1, 1'b0, 1'b0);
        run_op("REMU big/big", OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORMAL, 32'd1, 1'b0, 1'b0);
        run_op("DIV 0/5", OP_DIV, 32'd0, 32'd5, LAT_NORMAL, 32'd0, 1'b0, 1'b0);

        // Divide by zero
        run_op("DIVU x/0", OP_DIVU, 32'h1234, 32'd0, LAT_SPECIAL, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("REMU x/0", OP_REMU, 32'h1234, 32'd0, LAT_SPECIAL, 32'h1234, 1'b1, 1'b0);
        run_op("REM -7/0", OP_REM, 32'hFFFF_FFF9, 32'd0, LAT_SPECIAL, 32'hFFFF_FFF9, 1'b1, 1'b0);
        run_op("DIV -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, LAT_SPECIAL, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Signed overflow
        run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SPECIAL, 32'h8000_0000, 1'b0, 1'b1);
        run_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SPECIAL, 32'd0, 1'b0, 1'b1);
        run_op("DIVU no-ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, LAT_NORMAL, 32'd0, 1'b0, 1'b0);

        // Backpressure
        out_ready = 1'b0;
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'(LAT_NORMAL));
        check("bp result", result, 32'h0FFF_FFFF);
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
            check("bp hold result", result, held);
            check("bp hold flags", {30'd0, div_by_zero_flag, overflow_flag}, 32'd0);
            check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp single transfer", {31'd0, out_valid}, 32'd0);
        check("bp in_ready back", {31'd0, in_ready}, 32'd1);

        // Flush mid-CALC
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush blocks in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush idle in_ready", {31'd0, in_ready}, 32'd1);
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("flush no pulse", 32'(pulses), 32'd0);
        run_op("DIVU 9/3 after flush", OP_DIVU, 32'd9, 32'd3, LAT_NORMAL, 32'd3, 1'b0, 1'b0);

        // Flush in DONE with out_ready high and a coincident request
        out_ready = 1'b0;
        issue(OP_DIVU, 32'h1234, 32'd0);
        check("flushdone pending", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        div_op    = OP_DIVU;
        dividend  = 32'd8;
        divisor   = 32'd0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flushdone out_valid", {31'd0, out_valid}, 32'd0);
        check("flushdone flags", {30'd0, div_by_zero_flag, overflow_flag}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flushdone no accept", {31'd0, out_valid}, 32'd0);
        check("flushdone idle", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-CALC
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset in_ready", {31'd0, in_ready}, 32'd1);
        check("areset out_valid", {31'd0, out_valid}, 32'd0);
        check("areset result", result, 32'd0);
        check("areset flags", {30'd0, div_by_zero_flag, overflow_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("areset no pulse", 32'(pulses), 32'd0);
        run_op("DIVU 9/3 after reset", OP_DIVU, 32'd9, 32'd3, LAT_NORMAL, 32'd3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule

`default_nettype wire
